// File: rtl/pb_debouncer_pkg.sv
// Shared board timing header: system clock and default push-button timing,
// plus helpers that turn time units into clock-cycle counts.
package pb_debouncer_pkg;

  localparam int unsigned BOARD_CLK_HZ   = 40_000_000;
  localparam int unsigned PB_DEBOUNCE_US = 10_000;
  localparam int unsigned PB_LONG_MS     = 1_000;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return clk_hz / 1_000_000 * us;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1_000 * ms;
  endfunction

endpackage

// File: rtl/pb_debouncer_if.sv
// Push-button bundle: raw active-low buttons in, conditioned per-button
// level and event pulses out.
interface pb_debouncer_if #(
  parameter int NUM_PB = 4
);

  logic [NUM_PB-1:0] pb_n;
  logic [NUM_PB-1:0] pb_level;
  logic [NUM_PB-1:0] pb_press;
  logic [NUM_PB-1:0] pb_release;
  logic [NUM_PB-1:0] pb_long;

  modport master (
    output pb_n,
    input  pb_level, pb_press, pb_release, pb_long
  );

  modport slave (
    input  pb_n,
    output pb_level, pb_press, pb_release, pb_long
  );

endinterface

// File: rtl/pb_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, stability-window debounce,
// press/release edge pulses and a single-shot long-press detector.
module pb_debounce_ch #(
  parameter int DB_CYCLES   = 10,
  parameter int LONG_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pb_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam int LP_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic            sync1_q, sync2_q;
  logic            raw_s;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic [0:0]      lp_state_q, lp_state_d;
  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;

  assign raw_s = ~sync2_q;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (raw_s == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = raw_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign press_d   = stable_d & ~stable_q;
  assign release_d = ~stable_d & stable_q;

  // Keyed on stable_d so the counter clears on the same edge as the release pulse.
  always_comb begin
    lp_state_d = lp_state_q;
    lp_cnt_d   = lp_cnt_q;
    long_d     = 1'b0;
    if (!stable_d) begin
      lp_state_d = ST_IDLE;
      lp_cnt_d   = '0;
    end else if (lp_state_q == ST_IDLE && stable_q) begin
      if (lp_cnt_q == LP_LAST) begin
        long_d     = 1'b1;
        lp_state_d = ST_HELD;
      end else begin
        lp_cnt_d = lp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      lp_state_q <= ST_IDLE;
      lp_cnt_q   <= '0;
    end else begin
      sync1_q    <= pb_n_i;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      lp_state_q <= lp_state_d;
      lp_cnt_q   <= lp_cnt_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/pb_debouncer.sv
// Board push-button conditioning: one independent debounce channel per button,
// timing derived from the board clock frequency.
module pb_debouncer
  import pb_debouncer_pkg::*;
#(
  parameter int          NUM_PB      = 4,
  parameter int unsigned CLK_HZ      = BOARD_CLK_HZ,
  parameter int unsigned DEBOUNCE_US = PB_DEBOUNCE_US,
  parameter int unsigned LONG_MS     = PB_LONG_MS
) (
  input  logic           clk,
  input  logic           reset_n,
  pb_debouncer_if.slave  pb
);

  localparam int DB_CYCLES   = int'(us_to_cycles(CLK_HZ, DEBOUNCE_US));
  localparam int LONG_CYCLES = int'(ms_to_cycles(CLK_HZ, LONG_MS));

  logic [NUM_PB-1:0] level_w;
  logic [NUM_PB-1:0] press_w;
  logic [NUM_PB-1:0] release_w;
  logic [NUM_PB-1:0] long_w;

  for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_ch
    pb_debounce_ch #(
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .pb_n_i    (pb.pb_n[gi]),
      .level_o   (level_w[gi]),
      .press_o   (press_w[gi]),
      .release_o (release_w[gi]),
      .long_o    (long_w[gi])
    );
  end

  assign pb.pb_level   = level_w;
  assign pb.pb_press   = press_w;
  assign pb.pb_release = release_w;
  assign pb.pb_long    = long_w;

endmodule

// File: tb/tb_pb_debouncer.sv
// Bench for pb_debouncer: per-cycle reference model plus table vectors and
// hand-written bounce / reset-mid-press sequences.
module tb_pb_debouncer;

  localparam int NUM_PB = 4;
  localparam int DB     = 10;
  localparam int LONGC  = 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pb_debouncer_if #(.NUM_PB(NUM_PB)) pb_if ();

  pb_debouncer #(
    .NUM_PB      (NUM_PB),
    .CLK_HZ      (1000000),
    .DEBOUNCE_US (10),
    .LONG_MS     (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pb      (pb_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: window predicate over the delayed raw samples.
  logic [NUM_PB-1:0] m_stable, m_press, m_release, m_long;
  int                m_rise [NUM_PB];
  logic [NUM_PB-1:0] samp_q [$];
  logic [NUM_PB-1:0] raw_q  [$];
  int                cyc = 0;

  int n_press, n_release, n_long, first_press, first_long, phase_tick;

  typedef struct {
    int ch;
    int low_cycles;
    int exp_press;
    int exp_release;
    int exp_long;
  } vec_t;

  vec_t vecs [8];

  function automatic void model_reset();
    samp_q.delete();
    raw_q.delete();
    m_stable  = '0;
    m_press   = '0;
    m_release = '0;
    m_long    = '0;
    for (int i = 0; i < NUM_PB; i++) m_rise[i] = 0;
  endfunction

  function automatic void model_step();
    logic [NUM_PB-1:0] raw;
    bit all_diff;
    raw = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
    raw_q.push_back(raw);
    if (raw_q.size() > DB) void'(raw_q.pop_front());
    m_press   = '0;
    m_release = '0;
    m_long    = '0;
    for (int ch = 0; ch < NUM_PB; ch++) begin
      all_diff = (raw_q.size() == DB);
      for (int k = 0; k < raw_q.size(); k++)
        if (raw_q[k][ch] == m_stable[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[ch] = ~m_stable[ch];
        if (m_stable[ch]) begin
          m_press[ch] = 1'b1;
          m_rise[ch]  = cyc;
        end else begin
          m_release[ch] = 1'b1;
        end
      end
      if (m_stable[ch] && !m_press[ch] && (cyc - m_rise[ch] == LONGC)) m_long[ch] = 1'b1;
    end
    samp_q.push_back(~pb_if.pb_n);
    if (samp_q.size() > 2) void'(samp_q.pop_front());
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [4*NUM_PB-1:0] act, exp;
    act = {pb_if.pb_level, pb_if.pb_press, pb_if.pb_release, pb_if.pb_long};
    exp = {m_stable, m_press, m_release, m_long};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs cyc=%0d got lvl/prs/rel/lng=%h expected %h", cyc, act, exp);
    end
  endtask

  task automatic phase_begin();
    phase_tick  = 0;
    n_press     = 0;
    n_release   = 0;
    n_long      = 0;
    first_press = -1;
    first_long  = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset_n) model_step();
    else         model_reset();
    @(negedge clk);
    check_outputs();
    phase_tick++;
    n_press   += $countones(pb_if.pb_press);
    n_release += $countones(pb_if.pb_release);
    n_long    += $countones(pb_if.pb_long);
    if (pb_if.pb_press != '0 && first_press < 0) first_press = phase_tick;
    if (pb_if.pb_long  != '0 && first_long  < 0) first_long  = phase_tick;
  endtask

  int hold [NUM_PB];

  initial begin
    vecs[0] = '{ch: 0, low_cycles: 9,    exp_press: 0, exp_release: 0, exp_long: 0};
    vecs[1] = '{ch: 0, low_cycles: 10,   exp_press: 1, exp_release: 1, exp_long: 0};
    vecs[2] = '{ch: 1, low_cycles: 40,   exp_press: 1, exp_release: 1, exp_long: 0};
    vecs[3] = '{ch: 2, low_cycles: 1,    exp_press: 0, exp_release: 0, exp_long: 0};
    vecs[4] = '{ch: 3, low_cycles: 500,  exp_press: 1, exp_release: 1, exp_long: 0};
    vecs[5] = '{ch: 3, low_cycles: 1500, exp_press: 1, exp_release: 1, exp_long: 1};
    vecs[6] = '{ch: 0, low_cycles: 1000, exp_press: 1, exp_release: 1, exp_long: 0};
    vecs[7] = '{ch: 0, low_cycles: 1001, exp_press: 1, exp_release: 1, exp_long: 1};

    // Reset and idle
    pb_if.pb_n = '1;
    reset_n    = 1'b0;
    model_reset();
    phase_begin();
    repeat (3) tick();
    reset_n = 1'b1;
    phase_begin();
    repeat (100) tick();
    check_int("idle_press", n_press, 0);
    check_int("idle_release", n_release, 0);
    check_int("idle_long", n_long, 0);
    $display("reset/idle: press=%0d release=%0d long=%0d", n_press, n_release, n_long);

    // Table vectors: a single low pulse of given length on one channel
    for (int v = 0; v < 8; v++) begin
      phase_begin();
      pb_if.pb_n[vecs[v].ch] = 1'b0;
      repeat (vecs[v].low_cycles) tick();
      pb_if.pb_n[vecs[v].ch] = 1'b1;
      repeat (40) tick();
      check_int($sformatf("v%0d_press", v), n_press, vecs[v].exp_press);
      check_int($sformatf("v%0d_release", v), n_release, vecs[v].exp_release);
      check_int($sformatf("v%0d_long", v), n_long, vecs[v].exp_long);
      if (vecs[v].exp_press != 0) check_int($sformatf("v%0d_press_lat", v), first_press, DB + 2);
      if (vecs[v].exp_long != 0)  check_int($sformatf("v%0d_long_lat", v), first_long, DB + 2 + LONGC);
      $display("vec %0d ch=%0d low=%0d press=%0d release=%0d long=%0d",
               v, vecs[v].ch, vecs[v].low_cycles, n_press, n_release, n_long);
    end

    // Bounce on channel 2, then settle pressed
    phase_begin();
    for (int i = 0; i < 40; i++) begin
      pb_if.pb_n[2] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    check_int("bounce_no_press", n_press, 0);
    check_int("bounce_no_release", n_release, 0);
    pb_if.pb_n[2] = 1'b0;
    phase_begin();
    repeat (30) tick();
    check_int("bounce_press_cnt", n_press, 1);
    check_int("bounce_press_lat", first_press, DB + 2);
    pb_if.pb_n[2] = 1'b1;
    repeat (30) tick();
    $display("bounce: press=%0d at %0d release=%0d", n_press, first_press, n_release);

    // Randomised traffic on all channels against the model
    for (int c = 0; c < NUM_PB; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_PB; c++) begin
        if (hold[c] == 0) begin
          pb_if.pb_n[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 1200))
                                                : int'($urandom_range(1, 25));
        end
        hold[c]--;
      end
      tick();
    end
    pb_if.pb_n = '1;
    repeat (60) tick();
    $display("random: 3000 cycles done, errors so far %0d", errors);

    // Reset while channel 1 is held
    pb_if.pb_n[1] = 1'b0;
    phase_begin();
    repeat (20) tick();
    check_int("rst_pre_level", int'(pb_if.pb_level[1]), 1);
    reset_n = 1'b0;
    #1;
    check_int("rst_async_level", int'(pb_if.pb_level), 0);
    check_int("rst_async_pulses", int'({pb_if.pb_press, pb_if.pb_release, pb_if.pb_long}), 0);
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    phase_begin();
    for (int i = 0; i < 40 && first_press < 0; i++) tick();
    check_int("rst_repress_lat", first_press, DB + 2);
    check_int("rst_repress_level", int'(pb_if.pb_level[1]), 1);
    pb_if.pb_n[1] = 1'b1;
    repeat (30) tick();
    $display("reset mid-press: re-press at %0d", first_press);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
